// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//   LIFO data stack acting as the responder end of a stack CPU's push/pop
//   interface. Pushes complete in one cycle; pops return the word over a
//   valid/ready response channel. Tracks depth and raises sticky
//   overflow/underflow flags. The stack keeps operating after either flag sets.
//
// Parameters
//   WIDTH   data word width
//   DEPTH   number of entries (power of 2, >= 2)
//   AW      pointer width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  stack can accept a request (only in IDLE)
//   req_push   1 = push req_data, 0 = pop
//   req_data   push operand
//   rsp_valid  popped word valid
//   rsp_ready  core accepts popped word
//   rsp_data   popped word (0 on an underflowing pop)
//   depth      current entry count, 0..DEPTH
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
//   tos / nos  top / next-on-stack peek (only with DSTACK_PEEK_EN defined)
//
// Configuration macro
//   DSTACK_PEEK_EN  adds the combinational tos/nos peek ports.
// -----------------------------------------------------------------------------
module data_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_push,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [AW:0]      depth,
    output logic             overflow,
    output logic             underflow
`ifdef DSTACK_PEEK_EN
    ,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos
`endif
);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e             state_q, state_d;
    logic [AW:0]        depth_q, depth_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Storage is deliberately not reset; depth alone defines what is valid.
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               mem_we;

    logic               full;
    logic               empty;
    logic               push_acc;
    logic               pop_acc;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      top_idx;

    assign full     = (depth_q == DEPTH_W);
    assign empty    = (depth_q == '0);
    assign push_acc = req_valid && req_ready && req_push;
    assign pop_acc  = req_valid && req_ready && !req_push;

    // Low AW bits of depth wrap DEPTH to 0, so subtracting 1 in AW bits still
    // yields DEPTH-1 when the stack is full.
    assign wr_idx  = depth_q[AW-1:0];
    assign top_idx = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        rsp_data_d = rsp_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        mem_we     = 1'b0;
        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == RESP);

        case (state_q)
            IDLE: begin
                if (push_acc) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        depth_d = depth_q + (AW+1)'(1);
                    end
                end else if (pop_acc) begin
                    state_d = RESP;
                    if (empty) begin
                        rsp_data_d = '0;
                        unf_d      = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[top_idx];
                        depth_d    = depth_q - (AW+1)'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            rsp_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            rsp_data_q <= rsp_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= req_data;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef DSTACK_PEEK_EN
    logic [AW-1:0] nos_idx;
    assign nos_idx = depth_q[AW-1:0] - AW'(2);
    assign tos = (depth_q >= (AW+1)'(1)) ? mem_q[top_idx] : '0;
    assign nos = (depth_q >= (AW+1)'(2)) ? mem_q[nos_idx] : '0;
`endif

endmodule

// File: tb/tb_data_stack.sv
module tb_data_stack;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_push;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  depth;
    logic        overflow;
    logic        underflow;
`ifdef DSTACK_PEEK_EN
    logic [15:0] tos;
    logic [15:0] nos;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [15:0] mdl[$];
    bit          m_ovf;
    bit          m_unf;

    data_stack #(.WIDTH(16), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_push  (req_push),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef DSTACK_PEEK_EN
        ,
        .tos       (tos),
        .nos       (nos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_push(input logic [15:0] d);
        if (mdl.size() < 16) mdl.push_back(d);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [15:0] m_pop();
        if (mdl.size() == 0) begin
            m_unf = 1'b1;
            return 16'h0000;
        end
        return mdl.pop_back();
    endfunction

    function automatic logic [15:0] m_tos();
        return (mdl.size() >= 1) ? mdl[mdl.size()-1] : 16'h0000;
    endfunction

    function automatic logic [15:0] m_nos();
        return (mdl.size() >= 2) ? mdl[mdl.size()-2] : 16'h0000;
    endfunction

    // All drivers start just after a falling edge and return just after one.
    task automatic do_push(input logic [15:0] d);
        req_valid = 1'b1;
        req_push  = 1'b1;
        req_data  = d;
        m_push(d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Pop with rsp_ready withheld for 'stall' cycles; optionally drive stray
    // push requests during the stall. Returns what was observed.
    task automatic do_pop(input int stall, input bit junk,
                          output logic v0, output logic [15:0] d0,
                          output logic [4:0] dep0, output logic rr0,
                          output bit held, output logic v_after,
                          output logic [15:0] exp_d);
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_push  = 1'b0;
        req_data  = 16'($urandom);
        exp_d     = m_pop();
        @(negedge clk);
        req_valid = 1'b0;
        v0   = rsp_valid;
        d0   = rsp_data;
        dep0 = depth;
        rr0  = req_ready;
        held = 1'b1;
        for (int i = 0; i < stall; i++) begin
            req_valid = junk;
            req_push  = 1'b1;
            req_data  = 16'($urandom);
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_data === d0 &&
                  req_ready === 1'b0 && depth === dep0))
                held = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        v_after = rsp_valid;
    endtask

    task automatic drain();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        while (mdl.size() > 0)
            do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
    endtask

    task automatic test_reset();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        rst_n = 1'b0; req_valid = 1'b0; req_push = 1'b0;
        req_data = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (depth !== 5'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_data !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: depth=%0d rr=%b rv=%b rd=%h ovf=%b unf=%b, need 0 1 0 0000 0 0",
                     depth, req_ready, rsp_valid, rsp_data, overflow, underflow);
        end
        do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
        do_push(16'h0055);
        n_checks++;
        if (underflow !== 1'b1 || depth !== 5'd1) begin
            n_errors++;
            $display("FAIL pre_reset_state: unf=%b depth=%0d, need 1 1", underflow, depth);
        end
        // Pop left waiting for rsp_ready, then reset asynchronously mid-cycle.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_push  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (depth !== 5'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_data !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: depth=%0d rr=%b rv=%b rd=%h ovf=%b unf=%b, need 0 1 0 0000 0 0",
                     depth, req_ready, rsp_valid, rsp_data, overflow, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_lifo();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        do_push(16'h1111);
        do_push(16'h2222);
        do_push(16'h3333);
        n_checks++;
        if (depth !== 5'd3) begin
            n_errors++;
            $display("FAIL lifo_depth: depth=%0d need 3", depth);
        end
        for (int i = 0; i < 3; i++) begin
            do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
            n_checks++;
            if (v0 !== 1'b1 || d0 !== ed || dep0 !== 5'(mdl.size()) ||
                rr0 !== 1'b0 || va !== 1'b0) begin
                n_errors++;
                $display("FAIL lifo_pop%0d: rv=%b rd=%h depth=%0d rr=%b rv_after=%b, need 1 %h %0d 0 0",
                         i, v0, d0, dep0, rr0, va, ed, mdl.size());
            end
        end
    endtask

    task automatic test_overflow();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        drain();
        for (int i = 0; i < 16; i++) do_push(16'(i));
        n_checks++;
        if (depth !== 5'd16 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL fill: depth=%0d ovf=%b, need 16 0", depth, overflow);
        end
        do_push(16'hBEEF);
        n_checks++;
        if (depth !== 5'd16 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: depth=%0d ovf=%b, need 16 1", depth, overflow);
        end
        do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
        n_checks++;
        if (v0 !== 1'b1 || d0 !== ed || d0 !== 16'd15 || dep0 !== 5'd15) begin
            n_errors++;
            $display("FAIL pop_after_overflow: rv=%b rd=%h depth=%0d, need 1 000f 15",
                     v0, d0, dep0);
        end
    endtask

    task automatic test_underflow();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        drain();
        do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
        n_checks++;
        if (v0 !== 1'b1 || d0 !== 16'h0 || dep0 !== 5'd0 || underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow: rv=%b rd=%h depth=%0d unf=%b, need 1 0000 0 1",
                     v0, d0, dep0, underflow);
        end
        do_push(16'hC0DE);
        do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
        n_checks++;
        if (v0 !== 1'b1 || d0 !== 16'hC0DE || dep0 !== 5'd0 || underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL use_after_underflow: rv=%b rd=%h depth=%0d unf=%b, need 1 c0de 0 1",
                     v0, d0, dep0, underflow);
        end
    endtask

    task automatic test_stall();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        do_push(16'hA5A5);
        do_push(16'h5A5A);
        do_pop(5, 1'b1, v0, d0, dep0, rr0, held, va, ed);
        n_checks++;
        if (v0 !== 1'b1 || d0 !== ed || rr0 !== 1'b0 || !held || va !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold: rv=%b rd=%h rr=%b held=%0d rv_after=%b, need 1 %h 0 1 0",
                     v0, d0, rr0, held, va, ed);
        end
        n_checks++;
        if (depth !== 5'(mdl.size()) || overflow !== m_ovf) begin
            n_errors++;
            $display("FAIL stall_push_ignored: depth=%0d ovf=%b, need %0d %0d",
                     depth, overflow, mdl.size(), m_ovf);
        end
    endtask

`ifdef DSTACK_PEEK_EN
    task automatic test_peek();
        logic v0, rr0, va;
        logic [15:0] d0, ed;
        logic [4:0] dep0;
        bit held;
        drain();
        do_push(16'h000A);
        do_push(16'h000B);
        n_checks++;
        if (tos !== 16'h000B || nos !== 16'h000A) begin
            n_errors++;
            $display("FAIL peek_push: tos=%h nos=%h, need 000b 000a", tos, nos);
        end
        do_pop(0, 1'b0, v0, d0, dep0, rr0, held, va, ed);
        n_checks++;
        if (tos !== 16'h000A || nos !== 16'h0000) begin
            n_errors++;
            $display("FAIL peek_pop: tos=%h nos=%h, need 000a 0000", tos, nos);
        end
    endtask
`endif

    task automatic test_random();
        logic v0, rr0, va;
        logic [15:0] d0, ed, pd;
        logic [4:0] dep0;
        bit held;
        int bad;
        for (int i = 0; i < 300; i++) begin
            bad = 0;
            if ($urandom_range(0, 99) < 55) begin
                pd = 16'($urandom);
                do_push(pd);
                if (depth !== 5'(mdl.size()) || overflow !== m_ovf) bad = 1;
            end else begin
                do_pop(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                       v0, d0, dep0, rr0, held, va, ed);
                if (v0 !== 1'b1 || d0 !== ed || dep0 !== 5'(mdl.size()) ||
                    rr0 !== 1'b0 || !held || va !== 1'b0 || underflow !== m_unf)
                    bad = 1;
            end
`ifdef DSTACK_PEEK_EN
            if (tos !== m_tos() || nos !== m_nos()) bad = 1;
`endif
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL random_op%0d: depth=%0d ovf=%b unf=%b rd=%h, need depth=%0d ovf=%0d unf=%0d tos=%h nos=%h",
                         i, depth, overflow, underflow, rsp_data, mdl.size(), m_ovf, m_unf,
                         m_tos(), m_nos());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_stall();
`ifdef DSTACK_PEEK_EN
        test_peek();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, need completion");
        $fatal(1);
    end

endmodule
